// File: rtl/apb_pkg.sv
// Types shared by the APB initiator and its users: FSM state, command and response records.
// Struct widths use the default 32-bit data / 4-bit address configuration.
package apb_pkg;

    localparam int unsigned APB_REGWIDTH   = 32;
    localparam int unsigned APB_ADDR_WIDTH = 4;
    localparam int unsigned APB_STRB_WIDTH = APB_REGWIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    typedef struct packed {
        logic                      write;
        logic [APB_ADDR_WIDTH-1:0] addr;
        logic [APB_REGWIDTH-1:0]   wdata;
        logic [APB_STRB_WIDTH-1:0] strb;
        logic [2:0]                prot;
    } apb_cmd_t;

    typedef struct packed {
        logic [APB_REGWIDTH-1:0] rdata;
        logic                    err;
        logic                    timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_master_timeout.sv
// ACCESS-phase watchdog: counts PREADY-low ACCESS cycles and flags the one that would reach G_TIMEOUT.
// Only instantiated when APB_MASTER_TIMEOUT_EN is defined.
module apb_master_timeout
    import apb_pkg::*;
#(
    parameter int G_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_wait,
    output logic o_expired
);

    localparam int CNT_W = $clog2(G_TIMEOUT + 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_wait) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // r_count holds the low cycles already seen, so this cycle is number r_count+1.
    assign o_expired = i_wait && (r_count == CNT_W'(G_TIMEOUT - 1));

endmodule

// File: rtl/apb_master_if.sv
// APB4 initiator: one valid/ready command becomes one APB transfer whose result is returned on a
// valid/ready response stream. Define APB_MASTER_TIMEOUT_EN to abort transfers stuck in ACCESS.
module apb_master_if
    import apb_pkg::*;
#(
    parameter int G_REGWIDTH   = 32,
    parameter int G_ADDR_WIDTH = 4,
    parameter int G_TIMEOUT    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [G_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [G_REGWIDTH-1:0]   cmd_wdata,
    input  logic [G_REGWIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [G_REGWIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic                    m_apb_psel,
    output logic                    m_apb_penable,
    output logic                    m_apb_pwrite,
    output logic [2:0]              m_apb_pprot,
    output logic [G_ADDR_WIDTH-1:0] m_apb_paddr,
    output logic [G_REGWIDTH-1:0]   m_apb_pwdata,
    output logic [G_REGWIDTH/8-1:0] m_apb_pstrb,
    input  logic                    m_apb_pready,
    input  logic [G_REGWIDTH-1:0]   m_apb_prdata,
    input  logic                    m_apb_pslverr
);

    localparam int STRB_W = G_REGWIDTH / 8;

    apb_state_t r_state;
    apb_state_t w_next_state;

    logic                    r_write;
    logic [G_ADDR_WIDTH-1:0] r_addr;
    logic [G_REGWIDTH-1:0]   r_wdata;
    logic [STRB_W-1:0]       r_strb;
    logic [2:0]              r_prot;
    logic [G_REGWIDTH-1:0]   r_rdata;
    logic                    r_err;
    logic                    r_timeout;

    logic w_cmd_hs;
    logic w_done;
    logic w_expired;

    assign w_cmd_hs = (r_state == IDLE) && cmd_valid;
    assign w_done   = (r_state == ACCESS) && m_apb_pready;

`ifdef APB_MASTER_TIMEOUT_EN
    apb_master_timeout #(
        .G_TIMEOUT (G_TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (r_state == SETUP),
        .i_wait    ((r_state == ACCESS) && !m_apb_pready),
        .o_expired (w_expired)
    );
`else
    // G_TIMEOUT is legal only when >= 1, so without the watchdog this is constant 0.
    assign w_expired = (G_TIMEOUT < 1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        cmd_ready     = 1'b0;
        m_apb_psel    = 1'b0;
        m_apb_penable = 1'b0;
        rsp_valid     = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) w_next_state = SETUP;
            end
            SETUP: begin
                m_apb_psel   = 1'b1;
                w_next_state = ACCESS;
            end
            ACCESS: begin
                m_apb_psel    = 1'b1;
                m_apb_penable = 1'b1;
                if (w_done || w_expired) w_next_state = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Reads carry zero data and zero strobes on the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_prot  <= '0;
        end else if (w_cmd_hs) begin
            r_write <= cmd_write;
            r_addr  <= cmd_addr;
            r_wdata <= cmd_write ? cmd_wdata : '0;
            r_strb  <= cmd_write ? cmd_strb : '0;
            r_prot  <= cmd_prot;
        end
    end

    // PREADY has priority over an expiring watchdog in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
        end else if (w_done) begin
            r_rdata   <= r_write ? '0 : m_apb_prdata;
            r_err     <= m_apb_pslverr;
            r_timeout <= 1'b0;
        end else if (w_expired) begin
            r_rdata   <= '0;
            r_err     <= 1'b1;
            r_timeout <= 1'b1;
        end
    end

    assign m_apb_pwrite = r_write;
    assign m_apb_paddr  = r_addr;
    assign m_apb_pwdata = r_wdata;
    assign m_apb_pstrb  = r_strb;
    assign m_apb_pprot  = r_prot;
    assign rsp_rdata    = r_rdata;
    assign rsp_err      = r_err;
    assign rsp_timeout  = r_timeout;

endmodule

// File: tb/tb_apb_master_if.sv
// Bench for apb_master_if: directed vector table, stall/timeout and reset sequences, then random
// transfers checked against a rule-level model of the expected bus activity and response.
module tb_apb_master_if;
  import apb_pkg::*;

  localparam int RW  = 32;
  localparam int AW  = 4;
  localparam int SW  = RW / 8;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [RW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_strb = '0;
  logic [2:0]    cmd_prot = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [RW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          m_apb_psel;
  logic          m_apb_penable;
  logic          m_apb_pwrite;
  logic [2:0]    m_apb_pprot;
  logic [AW-1:0] m_apb_paddr;
  logic [RW-1:0] m_apb_pwdata;
  logic [SW-1:0] m_apb_pstrb;
  logic          m_apb_pready = 1'b0;
  logic [RW-1:0] m_apb_prdata = '0;
  logic          m_apb_pslverr = 1'b0;

  always #5 clk = ~clk;

  apb_master_if #(
    .G_REGWIDTH   (RW),
    .G_ADDR_WIDTH (AW),
    .G_TIMEOUT    (TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_strb      (cmd_strb),
    .cmd_prot      (cmd_prot),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .rsp_timeout   (rsp_timeout),
    .m_apb_psel    (m_apb_psel),
    .m_apb_penable (m_apb_penable),
    .m_apb_pwrite  (m_apb_pwrite),
    .m_apb_pprot   (m_apb_pprot),
    .m_apb_paddr   (m_apb_paddr),
    .m_apb_pwdata  (m_apb_pwdata),
    .m_apb_pstrb   (m_apb_pstrb),
    .m_apb_pready  (m_apb_pready),
    .m_apb_prdata  (m_apb_prdata),
    .m_apb_pslverr (m_apb_pslverr)
  );

  typedef struct {
    apb_cmd_t      cmd;
    int            waits;
    logic          slverr;
    logic [RW-1:0] prdata;
    int            rsp_delay;
    logic          hold_valid;
    apb_rsp_t      exp;
  } vec_t;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [AW-1:0] a, input logic [RW-1:0] wd,
                              input logic [SW-1:0] s, input logic [2:0] p, input int waits,
                              input logic se, input logic [RW-1:0] rd, input int dly,
                              input logic hold, input logic [RW-1:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.cmd        = '{write: w, addr: a, wdata: wd, strb: s, prot: p};
    v.waits      = waits;
    v.slverr     = se;
    v.prdata     = rd;
    v.rsp_delay  = dly;
    v.hold_valid = hold;
    v.exp        = '{rdata: exp_rdata, err: exp_err, timeout: 1'b0};
    return v;
  endfunction

  // Reference rules: writes return zero data, reads return the slave's data; error mirrors PSLVERR.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    r = v;
    r.exp.rdata   = v.cmd.write ? '0 : v.prdata;
    r.exp.err     = v.slverr;
    r.exp.timeout = 1'b0;
    return r;
  endfunction

  // Called at a falling edge with the DUT idle; returns at the falling edge after the rsp handshake.
  task automatic run_xfer(input vec_t v);
    logic [RW-1:0] exp_pwdata;
    logic [SW-1:0] exp_pstrb;
    int            last;
    exp_pwdata = v.cmd.write ? v.cmd.wdata : '0;
    exp_pstrb  = v.cmd.write ? v.cmd.strb : '0;
    last       = 2 + v.waits;
    chk("idle_cmd_ready", cmd_ready, 1'b1);
    chk("idle_rsp_valid", rsp_valid, 1'b0);
    cmd_valid = 1'b1;
    cmd_write = v.cmd.write;
    cmd_addr  = v.cmd.addr;
    cmd_wdata = v.cmd.wdata;
    cmd_strb  = v.cmd.strb;
    cmd_prot  = v.cmd.prot;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = v.hold_valid;
    cmd_write = 1'($urandom_range(0, 1));
    cmd_addr  = AW'($urandom);
    cmd_wdata = $urandom;
    cmd_strb  = SW'($urandom);
    cmd_prot  = 3'($urandom);
    for (int c = 1; c <= last; c++) begin
      chk("apb_psel", m_apb_psel, 1'b1);
      chk("apb_penable", m_apb_penable, (c >= 2));
      chk("apb_pwrite", m_apb_pwrite, v.cmd.write);
      chk("apb_paddr", m_apb_paddr, v.cmd.addr);
      chk("apb_pwdata", m_apb_pwdata, exp_pwdata);
      chk("apb_pstrb", m_apb_pstrb, exp_pstrb);
      chk("apb_pprot", m_apb_pprot, v.cmd.prot);
      chk("busy_rsp_valid", rsp_valid, 1'b0);
      chk("busy_cmd_ready", cmd_ready, 1'b0);
      m_apb_pready  = (c == 1) ? 1'($urandom_range(0, 1)) : (c == last);
      m_apb_prdata  = (c == last) ? v.prdata : $urandom;
      m_apb_pslverr = (c == last) ? v.slverr : 1'($urandom_range(0, 1));
      rsp_ready     = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
    end
    for (int d = 0; d <= v.rsp_delay; d++) begin
      m_apb_pready  = 1'($urandom_range(0, 1));
      m_apb_prdata  = $urandom;
      m_apb_pslverr = 1'($urandom_range(0, 1));
      chk("rsp_valid", rsp_valid, 1'b1);
      chk("rsp_rdata", rsp_rdata, v.exp.rdata);
      chk("rsp_err", rsp_err, v.exp.err);
      chk("rsp_timeout", rsp_timeout, v.exp.timeout);
      chk("resp_psel", m_apb_psel, 1'b0);
      chk("resp_penable", m_apb_penable, 1'b0);
      chk("resp_cmd_ready", cmd_ready, 1'b0);
      rsp_ready = (d == v.rsp_delay);
      @(posedge clk);
      @(negedge clk);
    end
    rsp_ready    = 1'b0;
    m_apb_pready = 1'b0;
    if (!v.hold_valid) cmd_valid = 1'b0;
  endtask

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int            STALL_LAST   = TMO + 1;
  localparam logic          STALL_FINISH = 1'b0;
  localparam logic [RW-1:0] STALL_RDATA  = '0;
`else
  localparam int            STALL_LAST   = 120;
  localparam logic          STALL_FINISH = 1'b1;
  localparam logic [RW-1:0] STALL_RDATA  = 32'h0000_55AA;
`endif

  vec_t vecs[6];
  vec_t rv;

  initial begin
    vecs[0] = mk(1'b1, 4'h4, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 1'b0, 32'h0BAD_0BAD, 0,  1'b0, 32'h0, 1'b0);
    vecs[1] = mk(1'b0, 4'h8, 32'hFFFF_FFFF, 4'hF, 3'd2, 3, 1'b0, 32'h1234_5678, 0,  1'b0, 32'h1234_5678, 1'b0);
    vecs[2] = mk(1'b1, 4'hC, 32'h0000_00A5, 4'h1, 3'd1, 1, 1'b1, 32'h0,         0,  1'b0, 32'h0, 1'b1);
    vecs[3] = mk(1'b0, 4'h0, 32'h0,         4'h0, 3'd5, 0, 1'b1, 32'hA5A5_5A5A, 1,  1'b0, 32'hA5A5_5A5A, 1'b1);
    vecs[4] = mk(1'b1, 4'h2, 32'hCAFE_F00D, 4'h6, 3'd4, 2, 1'b0, 32'h0000_1111, 10, 1'b1, 32'h0, 1'b0);
    vecs[5] = mk(1'b0, 4'hF, 32'h0,         4'hA, 3'd7, 2, 1'b0, 32'hFFFF_FFFF, 2,  1'b0, 32'hFFFF_FFFF, 1'b0);

    // Clock/reset.
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_psel", m_apb_psel, 1'b0);
    chk("rst_penable", m_apb_penable, 1'b0);
    chk("rst_pwrite", m_apb_pwrite, 1'b0);
    chk("rst_paddr", m_apb_paddr, '0);
    chk("rst_pwdata", m_apb_pwdata, '0);
    chk("rst_pstrb", m_apb_pstrb, '0);
    chk("rst_pprot", m_apb_pprot, '0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, '0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_rsp_timeout", rsp_timeout, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_xfer(vecs[i]);

    // PREADY held low: abort after TMO ACCESS cycles with the watchdog, otherwise wait it out.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 4'h5;
    cmd_prot  = 3'd3;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 1; c <= STALL_LAST; c++) begin
      chk("stall_psel", m_apb_psel, 1'b1);
      chk("stall_penable", m_apb_penable, (c >= 2));
      chk("stall_rsp_valid", rsp_valid, 1'b0);
      m_apb_pready  = STALL_FINISH && (c == STALL_LAST);
      m_apb_prdata  = 32'h0000_55AA;
      m_apb_pslverr = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    m_apb_pready = 1'b0;
    chk("stall_end_psel", m_apb_psel, 1'b0);
    chk("stall_end_penable", m_apb_penable, 1'b0);
    chk("stall_end_rsp_valid", rsp_valid, 1'b1);
    chk("stall_end_rdata", rsp_rdata, STALL_RDATA);
    chk("stall_end_err", rsp_err, !STALL_FINISH);
    chk("stall_end_timeout", rsp_timeout, !STALL_FINISH);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("stall_after_cmd_ready", cmd_ready, 1'b1);

    // Reset asserted mid-ACCESS.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 4'h9;
    cmd_wdata = 32'h1357_9BDF;
    cmd_strb  = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cmd_valid    = 1'b0;
    m_apb_pready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("prerst_penable", m_apb_penable, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_psel", m_apb_psel, 1'b0);
    chk("midrst_penable", m_apb_penable, 1'b0);
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    chk("midrst_cmd_ready", cmd_ready, 1'b1);
    chk("midrst_paddr", m_apb_paddr, '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_xfer(mk(1'b0, 4'h7, 32'h0, 4'h3, 3'd6, 1, 1'b0, 32'h7777_0001, 0, 1'b0, 32'h7777_0001, 1'b0));

    // Random transfers against the model.
    for (int i = 0; i < 30; i++) begin
      rv.cmd.write  = 1'($urandom_range(0, 1));
      rv.cmd.addr   = AW'($urandom);
      rv.cmd.wdata  = $urandom;
      rv.cmd.strb   = SW'($urandom);
      rv.cmd.prot   = 3'($urandom);
      rv.waits      = $urandom_range(0, 4);
      rv.slverr     = 1'($urandom_range(0, 1));
      rv.prdata     = $urandom;
      rv.rsp_delay  = $urandom_range(0, 3);
      rv.hold_valid = (i != 29) && ($urandom_range(0, 1) == 1);
      rv.exp        = '{rdata: '0, err: 1'b0, timeout: 1'b0};
      run_xfer(model(rv));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
